// File: rtl/quad_stim_gen.sv
// Quadrature / pushbutton stimulus generator: turns detent-step and press commands
// into registered A/B Gray-code waveforms and a PB level, tracking detent position.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | A/B at 00 detent, PB inactive, ready for a step or a press
//   STEP    | driving the three non-detent quadrature phases
//   SETTLE  | back at 00 (the fourth phase), held PHASE_CYC cycles
//   PRESS   | PB active for PB_SHORT or PB_LONG cycles
//   RELEASE | PB inactive debounce gap of PHASE_CYC cycles
module quad_stim_gen #(
    parameter int   PHASE_CYC = 16,
    parameter int   PB_SHORT  = 64,
    parameter int   PB_LONG   = 512,
    parameter logic PB_ACT    = 1'b1,
    parameter int   TMR_W     = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       step_valid,
    input  logic       step_dir,
    output logic       step_ready,
    input  logic       pb_valid,
    input  logic       pb_long,
    output logic       pb_ready,
    output logic       A,
    output logic       B,
    output logic       PB,
    output logic       busy,
    output logic [3:0] pos
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP    = 3'd1,
        SETTLE  = 3'd2,
        PRESS   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [TMR_W-1:0] PHASE_LD = TMR_W'(PHASE_CYC - 1);
    localparam logic [TMR_W-1:0] SHORT_LD = TMR_W'(PB_SHORT - 1);
    localparam logic [TMR_W-1:0] LONG_LD  = TMR_W'(PB_LONG - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [1:0]       ph, ph_nxt;
    logic             dir, dir_nxt;
    logic             lng, lng_nxt;
    logic             a_nxt, b_nxt, pb_nxt;
    logic [3:0]       pos_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            timer <= '0;
            ph    <= 2'd0;
            dir   <= 1'b0;
            lng   <= 1'b0;
            A     <= 1'b0;
            B     <= 1'b0;
            PB    <= ~PB_ACT;
            pos   <= 4'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            ph    <= ph_nxt;
            dir   <= dir_nxt;
            lng   <= lng_nxt;
            A     <= a_nxt;
            B     <= b_nxt;
            PB    <= pb_nxt;
            pos   <= pos_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = (timer != '0) ? timer - TMR_ONE : timer;
        ph_nxt    = ph;
        dir_nxt   = dir;
        lng_nxt   = lng;
        a_nxt     = A;
        b_nxt     = B;
        pb_nxt    = PB;
        pos_nxt   = pos;

        case (state)
            IDLE: begin
                a_nxt  = 1'b0;
                b_nxt  = 1'b0;
                pb_nxt = ~PB_ACT;
                // Timer is cleared on accept so the first phase launches on the next edge.
                if (step_valid) begin
                    state_nxt = STEP;
                    dir_nxt   = step_dir;
                    ph_nxt    = 2'd0;
                    timer_nxt = '0;
                end else if (pb_valid) begin
                    state_nxt = PRESS;
                    lng_nxt   = pb_long;
                    timer_nxt = '0;
                end
            end
            STEP: begin
                if (timer == '0) begin
                    timer_nxt = PHASE_LD;
                    ph_nxt    = ph + 2'd1;
                    case (ph)
                        2'd0: {a_nxt, b_nxt} = dir ? 2'b10 : 2'b01;
                        2'd1: {a_nxt, b_nxt} = 2'b11;
                        2'd2: {a_nxt, b_nxt} = dir ? 2'b01 : 2'b10;
                        default: begin
                            {a_nxt, b_nxt} = 2'b00;
                            pos_nxt        = dir ? pos + 4'd1 : pos - 4'd1;
                            state_nxt      = SETTLE;
                        end
                    endcase
                end
            end
            SETTLE: begin
                if (timer == '0) state_nxt = IDLE;
            end
            PRESS: begin
                // PB still inactive means this is the launch cycle of the press.
                if (PB != PB_ACT) begin
                    pb_nxt    = PB_ACT;
                    timer_nxt = lng ? LONG_LD : SHORT_LD;
                end else if (timer == '0) begin
                    pb_nxt    = ~PB_ACT;
                    state_nxt = RELEASE;
                    timer_nxt = PHASE_LD;
                end
            end
            RELEASE: begin
                if (timer == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign step_ready = (state == IDLE);
    assign pb_ready   = (state == IDLE) & ~step_valid;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_quad_stim_gen.sv
// Bench for quad_stim_gen: table of step/press commands feeding a scoreboard that is
// checked by a monitor watching A/B/PB, plus hand-written timing and reset sequences.
module tb_quad_stim_gen;

    localparam int PC  = 4;
    localparam int PBS = 64;
    localparam int PBL = 512;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       step_valid = 1'b0;
    logic       step_dir = 1'b0;
    logic       pb_valid = 1'b0;
    logic       pb_long = 1'b0;
    logic       step_ready, pb_ready, A, B, PB, busy;
    logic [3:0] pos;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    quad_stim_gen #(
        .PHASE_CYC(PC),
        .PB_SHORT (PBS),
        .PB_LONG  (PBL),
        .PB_ACT   (1'b1),
        .TMR_W    (10)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .step_valid(step_valid),
        .step_dir  (step_dir),
        .step_ready(step_ready),
        .pb_valid  (pb_valid),
        .pb_long   (pb_long),
        .pb_ready  (pb_ready),
        .A         (A),
        .B         (B),
        .PB        (PB),
        .busy      (busy),
        .pos       (pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_press;
        bit         dir;
        bit         lng;
        logic [3:0] pos;
        int         t0;
    } exp_t;

    typedef struct {
        bit         is_press;
        bit         dir;
        bit         lng;
        logic [3:0] pos;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each return of A/B to 00 completes a step, each PB fall completes a press.
    logic [1:0] prev_ab = 2'b00;
    logic       prev_pb = 1'b0;
    int         nchg = 0;
    logic [1:0] seq[4];
    int         tchg[4];
    int         t_on = 0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rstn) begin
            sbq.delete();
            nchg    = 0;
            prev_ab = 2'b00;
            prev_pb = 1'b0;
        end else begin
            if ({A, B} != prev_ab) begin
                if (nchg < 4) begin
                    seq[nchg]  = {A, B};
                    tchg[nchg] = cyc;
                end
                nchg++;
                if ({A, B} == 2'b00) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_step", 1, 0);
                    end else begin
                        mon_e = sbq.pop_front();
                        check("step_kind", int'(mon_e.is_press), 0);
                        check("ab_changes", nchg, 4);
                        if (nchg == 4) begin
                            check("ab_seq", int'({seq[0], seq[1], seq[2], seq[3]}),
                                  mon_e.dir ? 32'hB4 : 32'h78);
                            check("step_start", tchg[0], mon_e.t0);
                            for (int k = 1; k < 4; k++)
                                check("phase_len", tchg[k] - tchg[k-1], PC);
                        end
                        check("pos", int'(pos), int'(mon_e.pos));
                    end
                    nchg = 0;
                end
            end
            if (PB != prev_pb) begin
                if (PB) begin
                    t_on = cyc;
                end else if (sbq.size() == 0) begin
                    check("unexpected_press", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("press_kind", int'(mon_e.is_press), 1);
                    check("pb_start", t_on, mon_e.t0);
                    check("pb_width", cyc - t_on, mon_e.lng ? PBL : PBS);
                    check("ab_idle_in_press", nchg, 0);
                end
            end
            prev_ab = {A, B};
            prev_pb = PB;
        end
    end

    task automatic push_exp(input bit is_press, input bit dir, input bit lng,
                            input logic [3:0] p, input int acc);
        exp_t e;
        e.is_press = is_press;
        e.dir      = dir;
        e.lng      = lng;
        e.pos      = p;
        e.t0       = acc + 1;
        sbq.push_back(e);
    endtask

    // Holds the request until accepted; returns the accepting edge number.
    task automatic send(input bit is_press, input bit dir, input bit lng,
                        input logic [3:0] p, output int acc);
        int n;
        acc = -1;
        @(negedge clk);
        if (is_press) begin
            pb_valid = 1'b1;
            pb_long  = lng;
        end else begin
            step_valid = 1'b1;
            step_dir   = dir;
        end
        #1;
        n = 0;
        while (!(is_press ? pb_ready : step_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("accept_timeout", 0, 1);
        end else begin
            acc = cyc + 1;
            push_exp(is_press, dir, lng, p, acc);
            @(negedge clk);
        end
        step_valid = 1'b0;
        pb_valid   = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", sbq.size(), 0);
        n = 0;
        while (!step_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, a, t, n;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 4'd15};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 4'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 4'd15};

        // Reset held for three edges
        repeat (3) @(negedge clk);
        check("rst_a", int'(A), 0);
        check("rst_b", int'(B), 0);
        check("rst_pb", int'(PB), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_step_ready", int'(step_ready), 1);
        check("rst_pb_ready", int'(pb_ready), 1);
        check("rst_busy", int'(busy), 0);
        rstn = 1'b1;

        // First CW step: AB edges at acc+1/5/9/13, ready again at acc+17
        send(1'b0, 1'b1, 1'b0, 4'd1, acc);
        wait_until(acc + 2);
        check("busy_in_step", int'(busy), 1);
        wait_until(acc + 4*PC);
        check("step_ready_early", int'(step_ready), 0);
        wait_until(acc + 4*PC + 1);
        check("step_ready_back", int'(step_ready), 1);

        for (int i = 0; i < 7; i++)
            send(vecs[i].is_press, vecs[i].dir, vecs[i].lng, vecs[i].pos, acc);

        for (int i = 0; i < 16; i++)
            send(1'b0, 1'b1, 1'b0, 4'((15 + i + 1) % 16), acc);
        drain();

        // Simultaneous requests: step wins, press taken on first IDLE cycle
        @(negedge clk);
        step_valid = 1'b1;
        step_dir   = 1'b1;
        pb_valid   = 1'b1;
        pb_long    = 1'b0;
        #1;
        check("both_pb_ready", int'(pb_ready), 0);
        check("both_step_ready", int'(step_ready), 1);
        a = cyc + 1;
        push_exp(1'b0, 1'b1, 1'b0, 4'd0, a);
        @(negedge clk);
        step_valid = 1'b0;
        n = 0;
        while (!pb_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        check("press_after_step", t, a + 4*PC + 1);
        push_exp(1'b1, 1'b0, 1'b0, 4'd0, t + 1);
        @(negedge clk);
        pb_valid = 1'b0;
        drain();

        // Long press: PB high 512 cycles, low PHASE_CYC, then ready
        send(1'b1, 1'b0, 1'b1, 4'd0, acc);
        wait_until(acc + PBL + PC);
        check("long_pb_ready_early", int'(pb_ready), 0);
        check("long_pb_low", int'(PB), 0);
        wait_until(acc + PBL + PC + 1);
        check("long_pb_ready_back", int'(pb_ready), 1);
        drain();

        // Reset during phase 2 of a CW step
        send(1'b0, 1'b1, 1'b0, 4'd1, acc);
        drain();
        send(1'b0, 1'b1, 1'b0, 4'd2, acc);
        n = 0;
        while ({A, B} != 2'b11 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_phase2", int'({A, B}), 3);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_a", int'(A), 0);
        check("abort_b", int'(B), 0);
        check("abort_pos", int'(pos), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_step_ready", int'(step_ready), 1);
        rstn = 1'b1;

        send(1'b0, 1'b1, 1'b0, 4'd1, acc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
